// File: rtl/tm_stream_loader.sv
// Stream front-end for the Tsetlin Machine Inference block:
// loads clause masks, applies feature vectors, returns the class.
module tm_stream_loader #(
    parameter int N_FEATURES = 2,
    parameter int N_CLAUSES  = 8,
    parameter int CLASS_W    = 2,
    parameter int INFER_LAT  = 0,
    localparam int LIT_W     = 2 * N_FEATURES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         model_load,
    input  logic [LIT_W-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [N_FEATURES-1:0]        features,
    output logic [N_CLAUSES*LIT_W-1:0]   ex_flat,
    input  logic [CLASS_W-1:0]           class_in,
    output logic [CLASS_W-1:0]           result,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic                         model_valid,
    output logic                         busy
);

    localparam int IDX_W = (N_CLAUSES > 1) ? $clog2(N_CLAUSES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLAUSES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        APPLY,
        HOLD
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  wcnt;
    logic [3:0]        settle;
    logic [LIT_W-1:0]  mask_q [N_CLAUSES];
    logic              accept;

    assign in_ready = (state == LOAD) ||
                      (state == IDLE && model_valid && !model_load);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    genvar g;
    for (g = 0; g < N_CLAUSES; g++) begin : g_ex
        assign ex_flat[g*LIT_W +: LIT_W] = mask_q[g];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            wcnt         <= '0;
            settle       <= '0;
            features     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            model_valid  <= 1'b0;
            for (int k = 0; k < N_CLAUSES; k++) begin
                mask_q[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (model_load) begin
                        model_valid <= 1'b0;
                        wcnt        <= '0;
                        state       <= LOAD;
                    end else if (accept) begin
                        features <= in_data[N_FEATURES-1:0];
                        settle   <= 4'(INFER_LAT);
                        state    <= APPLY;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mask_q[wcnt] <= in_data;
                        if (wcnt == LAST) begin
                            model_valid <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                APPLY: begin
                    // Inference settles while the counter drains.
                    if (settle != 4'd0) begin
                        settle <= settle - 4'd1;
                    end else begin
                        result       <= class_in;
                        result_valid <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm_stream_loader.sv
// Bench for tm_stream_loader: two instances (settle 0 and 3)
// share one stream and are checked every cycle against a timestamp model.
module tb_tm_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        model_load;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        result_ready;
    logic [1:0]  noise;

    logic        rdy  [2];
    logic [1:0]  feat [2];
    logic [31:0] exf  [2];
    logic [1:0]  cls  [2];
    logic [1:0]  res  [2];
    logic        rvl  [2];
    logic        mvl  [2];
    logic        bsy  [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    // Reference Inference: a clause fires when all its included
    // literals are true; the class is the count of firing clauses mod 4.
    function automatic logic [1:0] cls_fn(logic [1:0] f, logic [31:0] ex);
        logic [3:0] lit;
        logic [3:0] m;
        int cnt;
        lit = {~f, f};
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            m = 4'(ex >> (4 * k));
            if ((m & ~lit) == 4'd0) cnt++;
        end
        return 2'(cnt);
    endfunction

    assign cls[0] = cls_fn(feat[0], exf[0]) ^ noise;
    assign cls[1] = cls_fn(feat[1], exf[1]) ^ noise;

    tm_stream_loader #(.INFER_LAT(0)) u_l0 (
        .clk(clk), .rst_n(rst_n), .model_load(model_load),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
        .features(feat[0]), .ex_flat(exf[0]), .class_in(cls[0]),
        .result(res[0]), .result_valid(rvl[0]),
        .result_ready(result_ready), .model_valid(mvl[0]), .busy(bsy[0])
    );

    tm_stream_loader #(.INFER_LAT(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .model_load(model_load),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
        .features(feat[1]), .ex_flat(exf[1]), .class_in(cls[1]),
        .result(res[1]), .result_valid(rvl[1]),
        .result_ready(result_ready), .model_valid(mvl[1]), .busy(bsy[1])
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    // Behavioural model: per instance, a loading flag, the mask table,
    // and the cycle a feature word was accepted (-1 when none in flight).
    int          LAT [2] = '{0, 3};
    bit          m_ld   [2];
    int          m_wc   [2];
    logic [3:0]  m_mask [2][8];
    bit          m_mv   [2];
    logic [1:0]  m_feat [2];
    logic [1:0]  m_res  [2];
    int          m_acc  [2] = '{-1, -1};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit          busy_e, rv_e, rdy_e;
            logic [31:0] ex_e;
            busy_e = m_ld[i] || (m_acc[i] >= 0);
            rv_e   = (m_acc[i] >= 0) && (cyc >= m_acc[i] + 2 + LAT[i]);
            rdy_e  = m_ld[i] || (!busy_e && m_mv[i] && !model_load);
            ex_e   = '0;
            for (int k = 0; k < 8; k++)
                ex_e |= 32'(m_mask[i][k]) << (4 * k);

            chk($sformatf("in_ready[%0d]", i), 32'(rdy[i]), 32'(rdy_e));
            chk($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(busy_e));
            chk($sformatf("features[%0d]", i), 32'(feat[i]), 32'(m_feat[i]));
            chk($sformatf("ex_flat[%0d]", i), exf[i], ex_e);
            chk($sformatf("model_valid[%0d]", i), 32'(mvl[i]), 32'(m_mv[i]));
            chk($sformatf("result_valid[%0d]", i), 32'(rvl[i]), 32'(rv_e));
            chk($sformatf("result[%0d]", i), 32'(res[i]), 32'(m_res[i]));

            if (!rst_n) begin
                m_ld[i]   = 1'b0;
                m_wc[i]   = 0;
                m_mv[i]   = 1'b0;
                m_feat[i] = '0;
                m_res[i]  = '0;
                m_acc[i]  = -1;
                for (int k = 0; k < 8; k++) m_mask[i][k] = '0;
            end else begin
                if (m_acc[i] >= 0 && cyc == m_acc[i] + 1 + LAT[i])
                    m_res[i] = cls_fn(m_feat[i], ex_e) ^ noise;
                if (rv_e && result_ready) m_acc[i] = -1;
                if (m_ld[i]) begin
                    if (in_valid) begin
                        m_mask[i][m_wc[i]] = in_data;
                        m_wc[i]++;
                        if (m_wc[i] == 8) begin
                            m_ld[i] = 1'b0;
                            m_mv[i] = 1'b1;
                        end
                    end
                end else if (!busy_e && model_load) begin
                    m_mv[i] = 1'b0;
                    m_ld[i] = 1'b1;
                    m_wc[i] = 0;
                end else if (rdy_e && in_valid) begin
                    m_feat[i] = in_data[1:0];
                    m_acc[i]  = cyc;
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] mset_a [8] = '{4'hC, 4'h9, 4'hC, 4'h6, 4'h5, 4'hC, 4'h1, 4'h3};
    logic [3:0] mset_b [8] = '{4'hA, 4'h5, 4'hF, 4'h0, 4'h3, 4'h7, 4'hE, 4'h8};

    initial begin
        rst_n = 1'b0; model_load = 1'b0; in_data = '0; in_valid = 1'b0;
        result_ready = 1'b1; noise = '0;
        repeat (3) step();
        rst_n = 1'b1;

        // Feature word presented before any model: must stay pending.
        in_valid = 1'b1; in_data = 4'h1;
        repeat (3) begin
            step();
            chk("preload_ready", 32'(rdy[0]), 32'd0);
            chk("preload_feat", 32'(feat[0]), 32'd0);
        end
        in_valid = 1'b0; model_load = 1'b1;
        #1 chk("load_cycle_ready", 32'(rdy[0]), 32'd0);
        step();
        model_load = 1'b0;
        for (int j = 0; j < 8; j++) begin
            in_valid = 1'b1; in_data = mset_a[j];
            #1 chk("mv_during_load", 32'(mvl[0]), 32'd0);
            step();
        end
        chk("mv_after_load", 32'(mvl[0]), 32'd1);
        chk("ex_flat_a", exf[0], 32'h31C56C9C);

        in_data = 4'h1;
        #1 chk("pending_ready", 32'(rdy[0]), 32'd1);
        step();
        in_valid = 1'b0;
        chk("pending_feat", 32'(feat[0]), 32'd1);
        chk("busy_t1", 32'(bsy[0]), 32'd1);
        chk("rv_t1", 32'(rvl[0]), 32'd0);
        step();
        chk("rv_t2", 32'(rvl[0]), 32'd1);
        chk("busy_t2", 32'(bsy[0]), 32'd1);
        chk("result_f01", 32'(res[0]), 32'd2);
        step();
        chk("idle_t3", 32'(rdy[0]), 32'd1);
        step();
        chk("rv3_t4", 32'(rvl[1]), 32'd0);
        step();
        chk("rv3_t5", 32'(rvl[1]), 32'd1);
        chk("result3_f01", 32'(res[1]), 32'd2);
        step();

        // features 2'b11, then stall the consumer for five cycles.
        in_valid = 1'b1; in_data = 4'h3;
        step();
        in_valid = 1'b0; result_ready = 1'b0;
        step();
        chk("rv_f11", 32'(rvl[0]), 32'd1);
        chk("result_f11", 32'(res[0]), 32'd2);
        for (int n = 0; n < 5; n++) begin
            noise = 2'($urandom);
            model_load = (n == 2);
            chk("hold_result", 32'(res[0]), 32'd2);
            chk("hold_ready", 32'(rdy[0]), 32'd0);
            chk("hold_rv", 32'(rvl[0]), 32'd1);
            step();
        end
        model_load = 1'b0; noise = '0; result_ready = 1'b1;
        step();
        chk("after_hold_ready", 32'(rdy[0]), 32'd1);
        chk("after_hold_ex", exf[0], 32'h31C56C9C);
        chk("after_hold_mv", 32'(mvl[0]), 32'd1);

        // Abort a load with reset after four words.
        model_load = 1'b1;
        step();
        model_load = 1'b0;
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1; in_data = 4'($urandom);
            step();
        end
        in_valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", 32'(rdy[i]), 32'd0);
            chk("rst_busy", 32'(bsy[i]), 32'd0);
            chk("rst_feat", 32'(feat[i]), 32'd0);
            chk("rst_ex", exf[i], 32'd0);
            chk("rst_mv", 32'(mvl[i]), 32'd0);
            chk("rst_rv", 32'(rvl[i]), 32'd0);
            chk("rst_res", 32'(res[i]), 32'd0);
        end
        model_load = 1'b1;
        step();
        model_load = 1'b0;
        for (int j = 0; j < 8; j++) begin
            in_valid = 1'b1; in_data = mset_b[j];
            step();
        end
        in_valid = 1'b0;
        chk("ex_flat_b", exf[1], 32'h8E730F5A);
        chk("mv_b", 32'(mvl[1]), 32'd1);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n        = ($urandom_range(0, 299) != 0);
            model_load   = ($urandom_range(0, 24) == 0);
            in_valid     = 1'($urandom_range(0, 1));
            in_data      = 4'($urandom);
            result_ready = ($urandom_range(0, 2) != 0);
            noise        = 2'($urandom);
            step();
        end
        rst_n = 1'b1; model_load = 1'b0; in_valid = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
